// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    localparam int DATA_W = 8;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request strictly after 'last', wrapping at N-1 -> 0.
module uart_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] idx
);

    function automatic logic [IW-1:0] cand(input logic [IW-1:0] base, input int step);
        return IW'((int'(base) + step) % N);
    endfunction

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Walk from farthest to nearest so the nearest candidate after 'last' overrides the rest.
        for (int k = N; k >= 1; k--) begin
            if (req[cand(last, k)]) begin
                found = 1'b1;
                idx   = cand(last, k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one UART transmit FIFO, with a mid-packet watchdog.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_req,
    input  logic                      tx_full,
    output logic                      grant_active,
    output logic [ID_W-1:0]           grant_id,
    output logic                      timeout_evt
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [ID_W-1:0]   last_grant;
    logic [CNT_W-1:0]  idle_cnt;
    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic              cur_valid;
    logic              cur_last;
    logic [DATA_W-1:0] cur_data;
    logic              hs;
    logic              release_pkt;
    logic              wd_fire;

    uart_rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_pick (
        .req   (req_valid),
        .last  (last_grant),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign cur_valid    = req_valid[grant_id];
    assign cur_last     = req_last[grant_id];
    assign cur_data     = req_data[int'(grant_id)*DATA_W +: DATA_W];
    assign hs           = (state == ARB_GRANT) && cur_valid && !tx_full;
    assign release_pkt  = hs && cur_last;
    assign grant_active = (state == ARB_GRANT);

    // The watchdog only fires on a silent owner; a valid owner stalled by tx_full is not idle.
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wd
            assign wd_fire = (state == ARB_GRANT) && !cur_valid &&
                             (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_wd
            assign wd_fire = 1'b0;
        end
    endgenerate

    always_comb begin
        req_ready = '0;
        if (state == ARB_GRANT) begin
            req_ready[grant_id] = ~tx_full;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:  if (pick_found) state_nxt = ARB_GRANT;
            ARB_GRANT: if (release_pkt || wd_fire) state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ARB_IDLE;
            last_grant  <= ID_W'(NUM_REQ - 1);
            grant_id    <= '0;
            tx_req      <= 1'b0;
            tx_data     <= '0;
            timeout_evt <= 1'b0;
            idle_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            tx_req      <= hs;
            timeout_evt <= wd_fire;
            if (hs) begin
                tx_data <= cur_data;
            end
            if (state == ARB_IDLE && pick_found) begin
                grant_id <= pick_idx;
            end
            if (release_pkt || wd_fire) begin
                last_grant <= grant_id;
            end
            if (state != ARB_GRANT || hs || wd_fire) begin
                idle_cnt <= '0;
            end else if (!cur_valid) begin
                idle_cnt <= idle_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized packet traffic.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ        = 4;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int ID_W           = 2;
    localparam int DEPTH          = 64;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*8-1:0]   req_data;
    logic [NUM_REQ-1:0]     req_last;
    logic [NUM_REQ-1:0]     req_ready;
    logic [7:0]             tx_data;
    logic                   tx_req;
    logic                   tx_full;
    logic                   grant_active;
    logic [ID_W-1:0]        grant_id;
    logic                   timeout_evt;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .ID_W           (ID_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_req       (tx_req),
        .tx_full      (tx_full),
        .grant_active (grant_active),
        .grant_id     (grant_id),
        .timeout_evt  (timeout_evt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Per-requester byte sources: {last, data}
    logic [8:0] src_mem [NUM_REQ][DEPTH];
    int         src_head  [NUM_REQ];
    int         src_tail  [NUM_REQ];
    int         src_sent  [NUM_REQ];
    int         src_limit [NUM_REQ];
    int         gap_run   [NUM_REQ];
    int         hs_cyc    [NUM_REQ];
    logic       mid_pkt   [NUM_REQ];
    logic       gap_mode, rand_full, full_force;

    int         cyc = 0;
    int         idle_run;
    logic       prev_active;
    logic [7:0] cap_q[$];
    logic [7:0] exp_q[$];
    int         gnt_q[$];
    int         idle_run_q[$];
    int         to_q[$];

    task automatic clear_tb();
        for (int i = 0; i < NUM_REQ; i++) begin
            src_head[i] = 0; src_tail[i] = 0; src_sent[i] = 0;
            src_limit[i] = 1000; gap_run[i] = 0; hs_cyc[i] = -1; mid_pkt[i] = 1'b0;
        end
        cap_q.delete(); gnt_q.delete(); idle_run_q.delete(); to_q.delete();
        gap_mode = 1'b0; rand_full = 1'b0; full_force = 1'b0;
        idle_run = 0; prev_active = 1'b0;
    endtask

    task automatic push_pkt(input int r, input logic [7:0] base, input int len);
        for (int k = 0; k < len; k++) begin
            src_mem[r][src_tail[r]] = {(k == len - 1), base + 8'(k)};
            src_tail[r]++;
        end
    endtask

    task automatic drive_sources();
        for (int i = 0; i < NUM_REQ; i++) begin
            logic v;
            v = (src_head[i] < src_tail[i]) && (src_sent[i] < src_limit[i]);
            if (v && gap_mode && mid_pkt[i] && gap_run[i] < 5 && $urandom_range(0, 2) == 0) begin
                v = 1'b0;
                gap_run[i]++;
            end
            req_valid[i]        = v;
            req_data[i*8 +: 8]  = v ? src_mem[i][src_head[i]][7:0] : 8'h00;
            req_last[i]         = v ? src_mem[i][src_head[i]][8] : 1'b0;
        end
        tx_full = rand_full ? ($urandom_range(0, 3) == 0) : full_force;
    endtask

    // One clock: drive at negedge, note handshakes, observe registered outputs just after posedge.
    task automatic cycle();
        logic [NUM_REQ-1:0] hs;
        drive_sources();
        #1;
        hs = req_valid & req_ready;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs[i]) begin
                mid_pkt[i] = !src_mem[i][src_head[i]][8];
                src_head[i]++;
                src_sent[i]++;
                gap_run[i] = 0;
                hs_cyc[i]  = cyc;
            end
        end
        #1;
        if (tx_req) cap_q.push_back(tx_data);
        if (timeout_evt) to_q.push_back(cyc);
        if (grant_active && !prev_active) begin
            gnt_q.push_back(int'(grant_id));
            idle_run_q.push_back(idle_run);
        end
        if (!grant_active) idle_run++; else idle_run = 0;
        prev_active = grant_active;
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_tb();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic run_until(input int n, input int budget, output logic ok);
        int c;
        c = 0;
        while (cap_q.size() < n && c < budget) begin
            cycle();
            c++;
        end
        ok = (cap_q.size() >= n);
    endtask

    // Packet-level round robin: whole packets in order of the next non-empty requester after the last owner.
    task automatic build_expected(input int first_last);
        int   ptr [NUM_REQ];
        int   last;
        logic any;
        exp_q.delete();
        for (int i = 0; i < NUM_REQ; i++) ptr[i] = src_head[i];
        last = first_last;
        do begin
            any = 1'b0;
            for (int k = 1; k <= NUM_REQ && !any; k++) begin
                int   j;
                logic done;
                j = (last + k) % NUM_REQ;
                if (ptr[j] < src_tail[j]) begin
                    any  = 1'b1;
                    last = j;
                    done = 1'b0;
                    while (!done) begin
                        exp_q.push_back(src_mem[j][ptr[j]][7:0]);
                        done = src_mem[j][ptr[j]][8];
                        ptr[j]++;
                    end
                end
            end
        end while (any);
    endtask

    task automatic check_stream(input string name);
        checks++;
        if (cap_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL %s_count: got %0d bytes, expected %0d", name, cap_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            logic [7:0] got;
            got = (k < cap_q.size()) ? cap_q[k] : 8'hxx;
            checks++;
            if (got !== exp_q[k]) begin
                failures++;
                $display("FAIL %s_byte%0d: got %02h expected %02h", name, k, got, exp_q[k]);
            end
        end
    endtask

    task automatic test_reset();
        clear_tb();
        push_pkt(0, 8'h11, 2);
        reset = 1'b1;
        cycle();
        cycle();
        checks++; if (tx_req !== 1'b0) begin failures++; $display("FAIL reset_tx_req: got %0b expected 0", tx_req); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %02h expected 00", tx_data); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        checks++; if (grant_active !== 1'b0) begin failures++; $display("FAIL reset_grant_active: got %0b expected 0", grant_active); end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        checks++; if (timeout_evt !== 1'b0) begin failures++; $display("FAIL reset_timeout_evt: got %0b expected 0", timeout_evt); end
        reset = 1'b0;
    endtask

    task automatic test_two_packets();
        logic ok;
        do_reset();
        push_pkt(0, 8'hA1, 3);
        push_pkt(2, 8'hC1, 3);
        exp_q.delete();
        exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
        exp_q.push_back(8'hC1); exp_q.push_back(8'hC2); exp_q.push_back(8'hC3);
        run_until(6, 60, ok);
        for (int i = 0; i < 10; i++) cycle();
        checks++; if (!ok) begin failures++; $display("FAIL two_pkt_budget: got %0d bytes expected 6", cap_q.size()); end
        check_stream("two_pkt");
    endtask

    task automatic test_rr_single();
        logic ok;
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NUM_REQ; i++) push_pkt(i, 8'((i << 4) | k), 1);
        run_until(8, 100, ok);
        for (int i = 0; i < 4; i++) cycle();
        checks++; if (!ok) begin failures++; $display("FAIL rr_budget: got %0d bytes expected 8", cap_q.size()); end
        checks++; if (gnt_q.size() !== 8) begin failures++; $display("FAIL rr_grant_count: got %0d expected 8", gnt_q.size()); end
        for (int k = 0; k < 8 && k < gnt_q.size(); k++) begin
            checks++;
            if (gnt_q[k] !== k % NUM_REQ) begin failures++; $display("FAIL rr_grant%0d: got %0d expected %0d", k, gnt_q[k], k % NUM_REQ); end
            if (k > 0) begin
                checks++;
                if (idle_run_q[k] !== 1) begin failures++; $display("FAIL rr_idle_gap%0d: got %0d expected 1", k, idle_run_q[k]); end
            end
        end
    endtask

    task automatic test_full_stall();
        logic ok;
        logic [NUM_REQ-1:0] rdy_seen;
        int n0;
        do_reset();
        push_pkt(1, 8'h50, 6);
        run_until(2, 30, ok);
        checks++; if (!ok) begin failures++; $display("FAIL stall_pre_budget: got %0d bytes expected 2", cap_q.size()); end
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL stall_ready_before: got %b expected 0010", req_ready); end
        full_force = 1'b1;
        n0 = cap_q.size();
        rdy_seen = '0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            rdy_seen |= req_ready;
        end
        checks++; if (rdy_seen !== 4'b0000) begin failures++; $display("FAIL stall_ready: got %b expected 0000", rdy_seen); end
        checks++; if (cap_q.size() !== n0) begin failures++; $display("FAIL stall_tx_req: got %0d bytes expected %0d", cap_q.size(), n0); end
        checks++; if (grant_active !== 1'b1 || grant_id !== 2'd1) begin
            failures++; $display("FAIL stall_grant: got active=%0b id=%0d expected active=1 id=1", grant_active, grant_id);
        end
        full_force = 1'b0;
        run_until(6, 40, ok);
        for (int i = 0; i < 4; i++) cycle();
        checks++; if (to_q.size() !== 0) begin failures++; $display("FAIL stall_timeout: got %0d pulses expected 0", to_q.size()); end
        exp_q.delete();
        for (int k = 0; k < 6; k++) exp_q.push_back(8'h50 + 8'(k));
        check_stream("stall");
    endtask

    task automatic test_timeout();
        int c;
        logic ok;
        do_reset();
        push_pkt(0, 8'h10, 4);
        push_pkt(1, 8'h20, 2);
        src_limit[0] = 1;
        c = 0;
        while (to_q.size() == 0 && c < 40) begin
            cycle();
            c++;
        end
        checks++; if (to_q.size() !== 1) begin failures++; $display("FAIL to_pulse_seen: got %0d pulses expected 1", to_q.size()); end
        if (to_q.size() > 0) begin
            checks++;
            if (to_q[0] + 1 - hs_cyc[0] !== TIMEOUT_CYCLES + 1) begin
                failures++; $display("FAIL to_latency: got %0d cycles expected %0d", to_q[0] + 1 - hs_cyc[0], TIMEOUT_CYCLES + 1);
            end
        end
        checks++; if (grant_active !== 1'b0) begin failures++; $display("FAIL to_released: got grant_active=%0b expected 0", grant_active); end
        run_until(3, 30, ok);
        for (int i = 0; i < 12; i++) cycle();
        checks++; if (to_q.size() !== 1) begin failures++; $display("FAIL to_single_pulse: got %0d pulses expected 1", to_q.size()); end
        checks++; if (gnt_q.size() < 2 || gnt_q[1] !== 1) begin
            failures++; $display("FAIL to_next_grant: got %0d grants (second=%0d) expected second grant 1", gnt_q.size(), (gnt_q.size() > 1) ? gnt_q[1] : -1);
        end
        exp_q.delete();
        exp_q.push_back(8'h10); exp_q.push_back(8'h20); exp_q.push_back(8'h21);
        check_stream("to");
    endtask

    task automatic test_reset_mid();
        logic ok;
        int n0;
        do_reset();
        push_pkt(1, 8'h60, 8);
        run_until(2, 30, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rst_mid_budget: got %0d bytes expected 2", cap_q.size()); end
        push_pkt(0, 8'h70, 2);
        gnt_q.delete();
        n0 = cap_q.size();
        reset = 1'b1;
        cycle();
        checks++; if (tx_req !== 1'b0 || cap_q.size() !== n0) begin failures++; $display("FAIL rst_mid_tx_req: got %0b expected 0", tx_req); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_mid_tx_data: got %02h expected 00", tx_data); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_mid_req_ready: got %b expected 0000", req_ready); end
        checks++; if (grant_active !== 1'b0) begin failures++; $display("FAIL rst_mid_grant_active: got %0b expected 0", grant_active); end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL rst_mid_grant_id: got %0d expected 0", grant_id); end
        checks++; if (timeout_evt !== 1'b0) begin failures++; $display("FAIL rst_mid_timeout_evt: got %0b expected 0", timeout_evt); end
        reset = 1'b0;
        for (int i = 0; i < 4 && gnt_q.size() == 0; i++) cycle();
        checks++; if (gnt_q.size() == 0 || gnt_q[0] !== 0) begin
            failures++; $display("FAIL rst_mid_first_grant: got %0d expected 0", (gnt_q.size() > 0) ? gnt_q[0] : -1);
        end
    endtask

    task automatic test_valid_on_timeout();
        int c;
        int h;
        logic ok;
        do_reset();
        push_pkt(3, 8'h30, 4);
        src_limit[3] = 1;
        c = 0;
        while (src_sent[3] < 1 && c < 20) begin
            cycle();
            c++;
        end
        checks++; if (src_sent[3] !== 1) begin failures++; $display("FAIL vot_first_byte: got %0d bytes accepted expected 1", src_sent[3]); end
        h = hs_cyc[3];
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) cycle();
        src_limit[3] = 100;
        cycle();
        checks++; if (hs_cyc[3] !== h + TIMEOUT_CYCLES) begin
            failures++; $display("FAIL vot_handshake_cycle: got %0d expected %0d", hs_cyc[3] - h, TIMEOUT_CYCLES);
        end
        run_until(4, 20, ok);
        for (int i = 0; i < 12; i++) cycle();
        checks++; if (to_q.size() !== 0) begin failures++; $display("FAIL vot_timeout: got %0d pulses expected 0", to_q.size()); end
        checks++; if (gnt_q.size() !== 1) begin failures++; $display("FAIL vot_grant_kept: got %0d grants expected 1", gnt_q.size()); end
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h30 + 8'(k));
        check_stream("vot");
    endtask

    task automatic test_random();
        logic ok;
        for (int iter = 0; iter < 3; iter++) begin
            do_reset();
            for (int i = 0; i < NUM_REQ; i++)
                for (int p = 0; p < 3; p++)
                    if ($urandom_range(0, 4) != 0) push_pkt(i, 8'($urandom_range(0, 255)), $urandom_range(1, 4));
            build_expected(NUM_REQ - 1);
            gap_mode  = 1'b1;
            rand_full = 1'b1;
            run_until(exp_q.size(), 800, ok);
            for (int i = 0; i < 10; i++) cycle();
            checks++; if (!ok) begin failures++; $display("FAIL rand%0d_budget: got %0d bytes expected %0d", iter, cap_q.size(), exp_q.size()); end
            checks++; if (to_q.size() !== 0) begin failures++; $display("FAIL rand%0d_timeout: got %0d pulses expected 0", iter, to_q.size()); end
            check_stream($sformatf("rand%0d", iter));
        end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        tx_full    = 1'b0;
        clear_tb();
        @(negedge clk);
        test_reset();
        test_two_packets();
        test_rr_single();
        test_full_stall();
        test_timeout();
        test_reset_mid();
        test_valid_on_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
